// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types for the instruction-fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        REDIR_BR  = 2'd0,
        REDIR_J   = 2'd1,
        REDIR_JR  = 2'd2,
        REDIR_RSV = 2'd3
    } redir_kind_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - combinational redirect target calculator
// IFU_JR_EN enables jump-register redirects; otherwise kind 2 is treated as reserved.
import ifu_pkg::*;

module ifu_next_pc #(
    parameter int PC_W = 30
) (
    input  logic [1:0]      redir_kind,
    input  logic [PC_W-1:0] redir_pc,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [31:0]     jr_addr,
    output logic [PC_W-1:0] target,
    output logic            kind_ok
);

    logic [PC_W+15:0] imm_wide;
    logic [PC_W+29:0] jr_wide;
    logic [PC_W-1:0]  br_t;
    logic [PC_W-1:0]  j_t;
    logic [PC_W-1:0]  jr_t;

    // Widening first lets one expression cover both truncation and extension for any PC_W.
    assign imm_wide = {{PC_W{imm16[15]}}, imm16};
    assign jr_wide  = {{PC_W{1'b0}}, jr_addr[31:2]};
    assign br_t     = redir_pc + PC_W'(1) + imm_wide[PC_W-1:0];
    assign jr_t     = jr_wide[PC_W-1:0];

    generate
        if (PC_W > 26) begin : g_j_wide
            assign j_t = {redir_pc[PC_W-1:26], addr26};
        end else begin : g_j_narrow
            assign j_t = addr26[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        target  = br_t;
        kind_ok = 1'b0;
        case (redir_kind_e'(redir_kind))
            REDIR_BR: kind_ok = 1'b1;
            REDIR_J: begin
                target  = j_t;
                kind_ok = 1'b1;
            end
            REDIR_JR: begin
`ifdef IFU_JR_EN
                target  = jr_t;
                kind_ok = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifdef IFU_JR_EN
    logic unused_bits;
    assign unused_bits = ^{jr_addr[1:0], imm_wide[PC_W+15:PC_W], jr_wide[PC_W+29:PC_W]};
`else
    logic unused_bits;
    assign unused_bits = ^{jr_addr[1:0], imm_wide[PC_W+15:PC_W], jr_wide[PC_W+29:PC_W], jr_t};
`endif

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - handshaked instruction-fetch unit with redirect and stale-fetch discard
// Optional jump-register redirects are built with IFU_JR_EN (see ifu_next_pc).
import ifu_pkg::*;

module ifu_fetch #(
    parameter int              PC_W     = 30,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            redir_valid,
    input  logic [1:0]      redir_kind,
    input  logic [PC_W-1:0] redir_pc,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [31:0]     jr_addr
);

    state_e            state;
    logic              stale;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   stored_target;
    logic [PC_W-1:0]   target;
    logic              kind_ok;
    logic              redir_hit;
    logic [PC_W+33:0]  addr_wide;

    ifu_next_pc #(.PC_W(PC_W)) u_next_pc (
        .redir_kind (redir_kind),
        .redir_pc   (redir_pc),
        .imm16      (imm16),
        .addr26     (addr26),
        .jr_addr    (jr_addr),
        .target     (target),
        .kind_ok    (kind_ok)
    );

    assign redir_hit = redir_valid & kind_ok;
    assign addr_wide = {32'd0, pc, 2'b00};
    assign imem_addr = addr_wide[31:0];

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_wide[PC_W+33:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FETCH;
            stale         <= 1'b0;
            pc            <= RESET_PC;
            stored_target <= '0;
            imem_req      <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            inst_valid    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                        if (redir_hit) pc <= target;
                    end else if (imem_ack) begin
                        if (stale || redir_hit) begin
                            // The returning word belongs to the old path; restart at the newest target.
                            stale <= 1'b0;
                            pc    <= redir_hit ? target : stored_target;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + PC_W'(1);
                            imem_req   <= 1'b0;
                            state      <= ST_HOLD;
                        end
                    end else if (redir_hit) begin
                        // The request cannot be withdrawn, so remember where to go once it lands.
                        stale         <= 1'b1;
                        stored_target <= target;
                    end
                end
                ST_HOLD: begin
                    if (redir_hit) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= ST_FETCH;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Parametrised, handshaked instruction-fetch unit for the MIPS core, successor to the single-cycle fetch path. It owns the word-addressed PC and issues one request at a time to a variable-latency instruction memory. It presents fetched instructions to decode with a valid/ready handshake. It accepts branch, jump and (optionally) jump-register redirects from decode and discards any in-flight stale fetch.

## Interface
Parameters:
- PC_W, 30: word-PC width; byte address is {pc, 2'b00}, zero-extended or truncated to 32 bits.
- RESET_PC, 0: word PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  byte address of request.
- imem_ack  in  1  request completed; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  instruction to decode.
- inst_pc  out  PC_W  word PC of inst.
- inst_valid  out  1  inst/inst_pc valid.
- inst_ready  in  1  decode accepts.
- redir_valid  in  1  redirect request.
- redir_kind  in  2  0 branch, 1 jump, 2 jr, 3 reserved (ignored).
- redir_pc  in  PC_W  word PC of the redirecting instruction.
- imm16  in  16  branch offset, in words.
- addr26  in  26  jump field.
- jr_addr  in  32  jr byte target; bits [1:0] ignored.

## Operation
- States: FETCH (imem_req=1), HOLD (inst_valid=1), plus a one-bit stale flag.
- Target arithmetic, modulo 2^PC_W:
  - branch: redir_pc + 1 + sext(imm16).
  - jump: {redir_pc[PC_W-1:26], addr26} when PC_W>26, else addr26[PC_W-1:0].
  - jr: jr_addr[PC_W+1:2], zero-extended when PC_W+2>32.
- FETCH:
  - imem_addr={pc,2'b00}.
  - On imem_ack with no stale and no redir_valid: latch inst=imem_rdata, inst_pc=pc, pc<=pc+1, go HOLD.
  - On imem_ack with stale or redir_valid: drop data, clear stale, pc<=target (if redir_valid) and stay FETCH.
  - redir_valid without ack: pc<=target is deferred. Store the target, set stale, keep imem_req/imem_addr unchanged until ack.
- HOLD:
  - inst_ready & !redir_valid: go FETCH at pc.
  - redir_valid (with or without inst_ready): drop inst, pc<=target, go FETCH. Redirect has priority.
- Reserved redir_kind: treated as no redirect.
- A second redirect while stale is set overwrites the stored target; the last redirect wins.
- pc wraps from 2^PC_W-1 to 0 silently.

## Timing
- Reset values: imem_req=0, inst_valid=0, inst=0, inst_pc=0, stale=0, pc=RESET_PC, state=FETCH. imem_req rises the first cycle after rst deasserts.
- imem_req and imem_addr are stable from assertion until the ack cycle. A request is never withdrawn except by rst.
- Same-cycle ack is legal.
- Throughput is 1 instruction per 2 cycles with zero-latency memory and ready always high.
- Latency:
  - inst_valid rises the cycle after ack.
  - A redirect in HOLD issues the target request the next cycle.
  - A redirect in FETCH issues the target request the cycle after the pending ack.
- inst, inst_pc and inst_valid are stable while inst_valid & !inst_ready & !redir_valid.
- rst mid-request abandons the request. The memory must tolerate imem_req dropping on reset.

## Configuration
- IFU_JR_EN:
  - Defined: redir_kind=2 redirects to jr_addr as above.
  - Undefined: the jr_addr port remains but is unused, and redir_kind=2 is treated as reserved (no redirect).

## Structure
- Shared package ifu_pkg:
  - redir_kind enum (REDIR_BR, REDIR_J, REDIR_JR).
  - State enum (ST_FETCH, ST_HOLD).
- Sub-module ifu_next_pc: combinational target calculator (redir_kind, redir_pc, imm16, addr26, jr_addr -> PC_W target). The IFU_JR_EN guard lives here.

## Test plan
- Reset, RESET_PC=0x100, zero-latency memory, ready=1 -> imem_addr 0x400, 0x404, 0x408 on every other cycle; inst_pc 0x100, 0x101, 0x102.
- Memory ack delayed 3 cycles; redirect branch from redir_pc=0x10 with imm16=0xFFFE raised in request cycle 1 -> stale data dropped; next request at word 0x0F (byte 0x3C).
- HOLD with ready=0 for 4 cycles -> inst and inst_pc stable; then jump with addr26=0x000040 and redir_pc=0x3FFFFFFF (PC_W=30) -> next imem_addr 0xF0000100.
- pc=2^PC_W-1, PC_W=8 -> following fetch at word 0, byte 0x000.
- With IFU_JR_EN, jr_addr=0x0000_1237 -> next imem_addr 0x1234. Without it, the same stimulus causes no redirect and the sequential fetch continues.
- rst asserted while imem_req high and ack pending -> next cycle imem_req=0 and inst_valid=0; fetch restarts at RESET_PC.
